// File: rtl/pe_filter_feeder_if.sv
// Filter feeder bus: set request, filter buffer read port and PE load port.
// master = feeder side, slave = buffer/PE/controller side.
interface pe_filter_feeder_if #(
    parameter int ADDR_W = 10,
    parameter int W_Tin  = 2,
    parameter int DATA_W = 288
);
    logic              i_start;
    logic [ADDR_W-1:0] i_base_addr;
    logic              i_swap_ok;
    logic              o_buf_rd_en;
    logic [ADDR_W-1:0] o_buf_rd_addr;
    logic [DATA_W-1:0] i_buf_rd_data;
    logic              o_load_filter;
    logic [W_Tin-1:0]  o_load_idx;
    logic [DATA_W-1:0] o_filter_data_flat;
    logic              o_change_filter;
    logic              o_busy;
    logic              o_done;

    modport master (
        input  i_start, i_base_addr, i_swap_ok, i_buf_rd_data,
        output o_buf_rd_en, o_buf_rd_addr, o_load_filter, o_load_idx,
        output o_filter_data_flat, o_change_filter, o_busy, o_done
    );

    modport slave (
        output i_start, i_base_addr, i_swap_ok, i_buf_rd_data,
        input  o_buf_rd_en, o_buf_rd_addr, o_load_filter, o_load_idx,
        input  o_filter_data_flat, o_change_filter, o_busy, o_done
    );
endinterface

// File: rtl/pe_filter_feeder.sv
// Fetches Tin filter words from the filter buffer into the PE shadow
// registers, then pulses change_filter once the PE reports it is idle.
module pe_filter_feeder #(
    parameter int Tin       = 4,
    parameter int Tout      = 4,
    parameter int FILTER_DW = 72,
    parameter int W_Tin     = 2,
    parameter int ADDR_W    = 10
) (
    input logic                clk,
    input logic                rstn,
    pe_filter_feeder_if.master bus
);
    localparam int DW = Tout * FILTER_DW;
    localparam logic [W_Tin-1:0] LAST = W_Tin'(Tin - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WAIT_SWAP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_base;
    logic [W_Tin-1:0]  r_cnt;
    logic              r_p1_v;
    logic [W_Tin-1:0]  r_p1_idx;
    logic              r_load;
    logic [W_Tin-1:0]  r_load_idx;
    logic [DW-1:0]     r_data;

    logic w_start;
    logic w_fetch;
    logic w_last_ld;
    logic w_swap;

    assign w_start   = (r_state == IDLE) && bus.i_start;
    assign w_fetch   = (r_state == FETCH);
    assign w_last_ld = r_load && (r_load_idx == LAST);
    assign w_swap    = (r_state == WAIT_SWAP) && bus.i_swap_ok;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; i_start outside IDLE is simply dropped
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:      if (bus.i_start)      w_next = FETCH;
            FETCH:     if (r_cnt == LAST)    w_next = DRAIN;
            DRAIN:     if (w_last_ld)        w_next = WAIT_SWAP;
            WAIT_SWAP: if (bus.i_swap_ok)    w_next = IDLE;
            default:                         w_next = IDLE;
        endcase
    end

    // Latch the set base address and step the read index
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_base <= '0;
            r_cnt  <= '0;
        end else if (w_start) begin
            r_base <= bus.i_base_addr;
            r_cnt  <= '0;
        end else if (w_fetch) begin
            r_cnt  <= r_cnt + W_Tin'(1);
        end
    end

    // Two-stage load pipe: read tag, then capture returning data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_p1_v     <= 1'b0;
            r_p1_idx   <= '0;
            r_load     <= 1'b0;
            r_load_idx <= '0;
            r_data     <= '0;
        end else begin
            r_p1_v   <= w_fetch;
            r_p1_idx <= r_cnt;
            r_load   <= r_p1_v;
            if (r_p1_v) begin
                r_load_idx <= r_p1_idx;
                r_data     <= bus.i_buf_rd_data;
            end
        end
    end

    assign bus.o_buf_rd_en        = w_fetch;
    assign bus.o_buf_rd_addr      = w_fetch ? (r_base + ADDR_W'(r_cnt)) : '0;
    assign bus.o_load_filter      = r_load;
    assign bus.o_load_idx         = r_load_idx;
    assign bus.o_filter_data_flat = r_data;
    assign bus.o_change_filter    = w_swap;
    assign bus.o_done             = w_swap;
    assign bus.o_busy             = (r_state != IDLE);
endmodule

// File: tb/tb_pe_filter_feeder.sv
// Scoreboard bench for pe_filter_feeder: stimulus pushes expected reads,
// loads, swaps and busy windows; a negedge monitor pops and compares.
module tb_pe_filter_feeder;
    localparam int TIN = 4;
    localparam int AW  = 10;
    localparam int WI  = 2;
    localparam int DW  = 4 * 72;
    localparam int NEVER = 32'h7fff_ffff;

    typedef struct { int c; logic [AW-1:0] a; } rd_t;
    typedef struct { int c; int idx; logic [DW-1:0] d; } ld_t;
    typedef struct { int lo; int hi; } win_t;

    logic clk = 0;
    logic rstn = 0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [DW-1:0] mem [1024];
    logic [DW-1:0] last_d = '0;

    rd_t  rdq[$];
    ld_t  ldq[$];
    int   swq[$];
    win_t bq[$];

    int win = NEVER;
    int swap_at = NEVER;
    int swp = 0;

    pe_filter_feeder_if #(.ADDR_W(AW), .W_Tin(WI), .DATA_W(DW)) bus ();

    pe_filter_feeder #(
        .Tin(TIN), .Tout(4), .FILTER_DW(72), .W_Tin(WI), .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural filter buffer: one-cycle read latency
    always @(posedge clk) begin
        if (bus.o_buf_rd_en) bus.i_buf_rd_data <= mem[bus.o_buf_rd_addr];
    end

    task automatic chk(input string nm, input logic ok,
                       input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rstn) begin
            chk("reset_zero",
                {bus.o_buf_rd_en, bus.o_buf_rd_addr, bus.o_load_filter,
                 bus.o_load_idx, bus.o_change_filter, bus.o_busy,
                 bus.o_done} == '0 && bus.o_filter_data_flat == '0,
                {bus.o_buf_rd_en, bus.o_load_filter, bus.o_change_filter,
                 bus.o_busy, bus.o_done}, '0);
        end else begin
            logic eb;
            eb = 1'b0;
            foreach (bq[i]) if (cyc >= bq[i].lo && cyc <= bq[i].hi) eb = 1'b1;
            chk("busy", bus.o_busy == eb, DW'(bus.o_busy), DW'(eb));
            chk("done_eq_change", bus.o_done == bus.o_change_filter,
                DW'(bus.o_done), DW'(bus.o_change_filter));
            if (bus.o_buf_rd_en) begin
                if (rdq.size() == 0) begin
                    chk("unexpected_read", 1'b0, DW'(bus.o_buf_rd_addr), '0);
                end else begin
                    rd_t r;
                    r = rdq.pop_front();
                    chk("read_cycle", cyc == r.c, DW'(cyc), DW'(r.c));
                    chk("read_addr", bus.o_buf_rd_addr == r.a,
                        DW'(bus.o_buf_rd_addr), DW'(r.a));
                end
            end
            if (bus.o_load_filter) begin
                if (ldq.size() == 0) begin
                    chk("unexpected_load", 1'b0, DW'(bus.o_load_idx), '0);
                end else begin
                    ld_t l;
                    l = ldq.pop_front();
                    chk("load_cycle", cyc == l.c, DW'(cyc), DW'(l.c));
                    chk("load_idx", int'(bus.o_load_idx) == l.idx,
                        DW'(bus.o_load_idx), DW'(l.idx));
                    chk("load_data", bus.o_filter_data_flat == l.d,
                        bus.o_filter_data_flat, l.d);
                    last_d = l.d;
                end
            end else begin
                chk("data_hold", bus.o_filter_data_flat == last_d,
                    bus.o_filter_data_flat, last_d);
            end
            if (bus.o_change_filter) begin
                if (swq.size() == 0) begin
                    chk("unexpected_change", 1'b0, DW'(cyc), '0);
                end else begin
                    int s;
                    s = swq.pop_front();
                    chk("change_cycle", cyc == s, DW'(cyc), DW'(s));
                end
            end
        end
    end

    // Advance one cycle; swap_ok is random outside the swap window
    task automatic tick();
        @(posedge clk);
        #1;
        if (cyc >= win && cyc <= swp) bus.i_swap_ok = (cyc >= swap_at);
        else                          bus.i_swap_ok = 1'($urandom);
    endtask

    task automatic start_set(input logic [AW-1:0] base, input int extra);
        int s;
        s = cyc;
        bus.i_start = 1'b1;
        bus.i_base_addr = base;
        win = s + TIN + 3;
        swap_at = win + extra;
        swp = swap_at;
        for (int k = 0; k < TIN; k++) begin
            logic [AW-1:0] a;
            a = AW'(int'(base) + k);
            rdq.push_back('{s + 1 + k, a});
            ldq.push_back('{s + 3 + k, k, mem[a]});
        end
        swq.push_back(swp);
        bq.push_back('{s + 1, swp});
        tick();
        bus.i_start = 1'b0;
        bus.i_base_addr = AW'($urandom);
    endtask

    task automatic wait_set();
        while (cyc <= swp) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int n = 0; n < 1024; n++)
            for (int w = 0; w < DW / 32; w++) mem[n][w*32 +: 32] = $urandom;
        bus.i_start = 1'b0;
        bus.i_base_addr = '0;
        bus.i_swap_ok = 1'b0;
        bus.i_buf_rd_data = '0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        // Nominal set
        start_set(10'h010, 0);
        wait_set();
        tick();

        // Swap stall
        start_set(10'h123, 13);
        wait_set();
        tick();

        // Address wrap
        start_set(10'h3FE, 0);
        wait_set();
        tick();

        // Start while busy is ignored
        start_set(10'h200, 2);
        tick();
        tick();
        bus.i_start = 1'b1;
        bus.i_base_addr = 10'h155;
        tick();
        bus.i_start = 1'b0;
        wait_set();
        tick();

        // Reset mid-set
        start_set(10'h0A0, 0);
        repeat (3) tick();
        rstn = 1'b0;
        rdq.delete();
        ldq.delete();
        swq.delete();
        bq.delete();
        win = NEVER;
        swp = 0;
        last_d = '0;
        repeat (2) tick();
        rstn = 1'b1;
        repeat (10) tick();

        // Back-to-back sets
        start_set(10'h040, 0);
        wait_set();
        start_set(10'h050, 1);
        wait_set();
        tick();

        // Random sets, sometimes back-to-back
        for (int i = 0; i < 8; i++) begin
            start_set(AW'($urandom), int'($urandom_range(0, 4)));
            wait_set();
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (6) tick();
        chk("reads_left", rdq.size() == 0, DW'(rdq.size()), '0);
        chk("loads_left", ldq.size() == 0, DW'(ldq.size()), '0);
        chk("swaps_left", swq.size() == 0, DW'(swq.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
